// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_dot_sched dot-product sequencer.
// Optional build macro: MAC_DOT_SATURATE_EN (clamp accumulator on overflow).
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int W_DEF     = 8;
    localparam int ACCW_DEF  = 16;
    localparam int LEN_W_DEF = 8;

    // Largest positive two's-complement value representable in accw bits.
    function automatic logic signed [63:0] sat_max(input int accw);
        return (64'sd1 <<< (accw - 1)) - 64'sd1;
    endfunction

    // Most negative two's-complement value representable in accw bits.
    function automatic logic signed [63:0] sat_min(input int accw);
        return -(64'sd1 <<< (accw - 1));
    endfunction

endpackage

// File: rtl/mac_core.sv
// Two-stage signed multiply/accumulate pipeline.
// Stage 1 registers the operands, stage 2 registers the product, and the
// accumulator absorbs the product one edge later. With MAC_DOT_SATURATE_EN
// defined the accumulator clamps on overflow instead of wrapping.
module mac_core
    import mac_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [W-1:0]    a,
    input  logic signed [W-1:0]    b,
    output logic signed [ACCW-1:0] acc,
    output logic                   ovf,
    output logic [1:0]             stage_v
);

`ifdef MAC_DOT_SATURATE_EN
    localparam logic signed [ACCW-1:0] ACC_MAX = ACCW'(sat_max(ACCW));
    localparam logic signed [ACCW-1:0] ACC_MIN = ACCW'(sat_min(ACCW));
`endif

    logic signed [W-1:0]    a_q;
    logic signed [W-1:0]    b_q;
    logic signed [2*W-1:0]  prod_q;
    logic                   v1_q;
    logic                   v2_q;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic signed [ACCW-1:0] addend_s;
    logic signed [ACCW-1:0] sum_s;
    logic                   add_ovf_s;

    // Operand and product pipeline registers with their valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else if (clr) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            v1_q <= en;
            v2_q <= v1_q;
            if (en) begin
                a_q <= a;
                b_q <= b;
            end
            if (v1_q) begin
                prod_q <= a_q * b_q;
            end
        end
    end

    assign addend_s  = ACCW'(prod_q);
    assign sum_s     = acc_q + addend_s;
    assign add_ovf_s = (acc_q[ACCW-1] == addend_s[ACCW-1]) &&
                       (sum_s[ACCW-1] != acc_q[ACCW-1]);

    // Next accumulator value and sticky overflow flag.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (v2_q) begin
            ovf_d = ovf_q | add_ovf_s;
`ifdef MAC_DOT_SATURATE_EN
            if (add_ovf_s) begin
                acc_d = acc_q[ACCW-1] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_d = sum_s;
            end
`else
            acc_d = sum_s;
`endif
        end else begin
            acc_d = acc_q;
            ovf_d = ovf_q;
        end
    end

    // Accumulator and overflow registers, cleared at each vector start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc     = acc_q;
    assign ovf     = ovf_q;
    assign stage_v = {v2_q, v1_q};

endmodule

// File: rtl/mac_dot_sched.sv
// Dot-product sequencer: captures a vector length, streams operand pairs
// into mac_core under valid/ready, and presents one result per vector.
// Optional build macro: MAC_DOT_SATURATE_EN (handled inside mac_core).
module mac_dot_sched
    import mac_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int ACCW  = ACCW_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    input  logic signed [W-1:0]    a,
    input  logic signed [W-1:0]    b,
    input  logic                   valid_in,
    output logic                   ready_in,
    output logic signed [ACCW-1:0] f,
    output logic                   overflow,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic                   busy
);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic             ready_in_q;
    logic             valid_out_q;
    logic             busy_q;
    logic             clr_s;
    logic             accept_s;
    logic [1:0]       stage_v_s;

    mac_core #(
        .W    (W),
        .ACCW (ACCW)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_s),
        .en      (accept_s),
        .a       (a),
        .b       (b),
        .acc     (f),
        .ovf     (overflow),
        .stage_v (stage_v_s)
    );

    // Next-state, element counter and datapath controls.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_s    = 1'b0;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr_s = 1'b1;
                    if (len != LEN_W'(0)) begin
                        state_d = ST_RUN;
                        cnt_d   = len;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (valid_in && ready_in_q) begin
                    accept_s = 1'b1;
                    cnt_d    = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Last product sits in stage 2 and is absorbed on this edge.
                if (stage_v_s == 2'b10) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (ready_out) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_in_q  <= 1'b0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_in_q  <= (state_d == ST_RUN);
            valid_out_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign ready_in  = ready_in_q;
    assign valid_out = valid_out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_dot_sched.sv
// Self-checking bench for mac_dot_sched: directed vectors plus random ones,
// each result compared with an integer dot-product reference model.
module tb_mac_dot_sched;

    localparam int W     = 8;
    localparam int ACCW  = 16;
    localparam int LEN_W = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [LEN_W-1:0]       len = '0;
    logic signed [W-1:0]    a = '0;
    logic signed [W-1:0]    b = '0;
    logic                   valid_in = 1'b0;
    logic                   ready_in;
    logic signed [ACCW-1:0] f;
    logic                   overflow;
    logic                   valid_out;
    logic                   ready_out = 1'b0;
    logic                   busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic signed [W-1:0]    va [16];
    logic signed [W-1:0]    vb [16];
    logic signed [ACCW-1:0] exp_f;
    logic                   exp_o;

    mac_dot_sched #(.W(W), .ACCW(ACCW), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .f         (f),
        .overflow  (overflow),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: exact integer sum, wrapped or clamped to 16 bits at each step.
    task automatic ref_model(input int n);
        longint s;
        s = 0;
        exp_o = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + longint'(int'(va[i]) * int'(vb[i]));
`ifdef MAC_DOT_SATURATE_EN
            if (s > 32767) begin s = 32767; exp_o = 1'b1; end
            else if (s < -32768) begin s = -32768; exp_o = 1'b1; end
`else
            if (s > 32767) begin s = s - 65536; exp_o = 1'b1; end
            else if (s < -32768) begin s = s + 65536; exp_o = 1'b1; end
`endif
        end
        exp_f = 16'(s);
    endtask

    function automatic int next_gap(input int gap);
        return (gap >= 0) ? gap : int'($urandom_range(0, 2));
    endfunction

    // Start a vector of n elements from va/vb and check the result timing.
    task automatic run_vec(input int n, input int gap);
        int idx;
        int cyc;
        int wait_c;
        bit acc_now;
        idx = 0;
        cyc = 0;
        wait_c = 0;
        @(negedge clk);
        start = 1'b1;
        len = 8'(n);
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            ref_model(0);
            chk("len0_vo", valid_out, 1);
            chk("len0_rdy", ready_in, 0);
            chk("len0_f", f, 0);
            chk("len0_ovf", overflow, 0);
            return;
        end
        chk("run_busy", busy, 1);
        while (idx < n && cyc < 200) begin
            if (wait_c > 0) begin
                valid_in = 1'b0;
                wait_c--;
            end else begin
                valid_in = 1'b1;
                a = va[idx];
                b = vb[idx];
            end
            chk("run_rdy", ready_in, 1);
            acc_now = valid_in && ready_in;
            @(negedge clk);
            cyc++;
            if (acc_now) begin
                idx++;
                wait_c = next_gap(gap);
            end
        end
        chk("accepts", idx, n);
        valid_in = 1'b0;
        chk("rdy_drop", ready_in, 0);
        chk("vo_k0", valid_out, 0);
        @(negedge clk);
        chk("vo_k1", valid_out, 0);
        @(negedge clk);
        ref_model(n);
        chk("vo_k2", valid_out, 1);
        chk("result_f", f, exp_f);
        chk("result_ovf", overflow, exp_o);
    endtask

    // Stall the result for hold cycles, then take it.
    task automatic finish_vec(input int hold, input bit start_mid, input bit start_take);
        for (int i = 0; i < hold; i++) begin
            ready_out = 1'b0;
            start = (start_mid && i == 1);
            len = 8'd3;
            @(negedge clk);
            chk("hold_vo", valid_out, 1);
            chk("hold_f", f, exp_f);
            chk("hold_ovf", overflow, exp_o);
        end
        ready_out = 1'b1;
        start = start_take;
        len = 8'd3;
        @(negedge clk);
        chk("vo_drop", valid_out, 0);
        chk("idle_busy", busy, 0);
        ready_out = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("stay_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;
        int n;
        bit acc_now;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy", ready_in, 0);
        chk("rst_vo", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_f", f, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;

        // 1: small mixed-sign vector; start coincides with taking the result
        va[0] = 8'sd2;   vb[0] = 8'sd2;
        va[1] = 8'sd3;   vb[1] = -8'sd3;
        va[2] = 8'sd5;   vb[2] = 8'sd5;
        run_vec(3, 0);
        chk("t1_f", f, 20);
        finish_vec(0, 1'b0, 1'b1);

        // 2: positive overflow
        for (int i = 0; i < 3; i++) begin va[i] = 8'sd125; vb[i] = 8'sd100; end
        run_vec(3, 0);
`ifdef MAC_DOT_SATURATE_EN
        chk("t2_f", f, 32767);
`else
        chk("t2_f", f, -28036);
`endif
        chk("t2_ovf", overflow, 1);
        finish_vec(0, 1'b0, 1'b0);

        // 3: negative overflow
        for (int i = 0; i < 3; i++) begin va[i] = -8'sd125; vb[i] = 8'sd120; end
        run_vec(3, 0);
`ifdef MAC_DOT_SATURATE_EN
        chk("t3_f", f, -32768);
`else
        chk("t3_f", f, 20536);
`endif
        chk("t3_ovf", overflow, 1);
        finish_vec(0, 1'b0, 1'b0);

        // 4: bubbles between pairs, then backpressure with a stray start
        for (int i = 0; i < 4; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 1); end
        run_vec(4, 2);
        chk("t4_f", f, 30);
        finish_vec(5, 1'b1, 1'b0);

        // 5: zero-length vector, operand offered but not taken
        valid_in = 1'b1;
        a = 8'sd9;
        b = 8'sd9;
        run_vec(0, 0);
        finish_vec(0, 1'b0, 1'b0);
        valid_in = 1'b0;

        // 6: reset in the middle of a vector
        @(negedge clk);
        start = 1'b1;
        len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        guard = 0;
        while (cnt < 2 && guard < 50) begin
            valid_in = 1'b1;
            a = 8'sd9;
            b = 8'sd9;
            acc_now = ready_in;
            @(negedge clk);
            if (acc_now) cnt++;
            guard++;
        end
        valid_in = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rdy", ready_in, 0);
        chk("mid_rst_vo", valid_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_f", f, 0);
        chk("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        va[0] = 8'sd7;
        vb[0] = -8'sd7;
        run_vec(1, 0);
        chk("t6_f", f, -49);
        chk("t6_ovf", overflow, 0);
        finish_vec(0, 1'b0, 1'b0);

        // Random vectors with random bubbles and result stalls
        for (int v = 0; v < 8; v++) begin
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
            end
            run_vec(n, -1);
            finish_vec(int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
